// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: the writeback entry carried from the LSU
// into the commit queue.
package cpu_types_pkg;

   localparam int RD_W     = 5;
   localparam int CPU_XLEN = 32;

   // Field subset of lsu_wb_t without the valid bit.
   typedef struct packed {
      logic [RD_W-1:0]     rd_addr;
      logic [CPU_XLEN-1:0] wb_data;
      logic                reg_wen;
      logic [CPU_XLEN-1:0] pc_target;
   } wb_entry_t;

   function automatic int entry_w(input int xlen);
      return RD_W + 2 * xlen + 1;
   endfunction

endpackage

// File: rtl/wbu_commit_queue_if.sv
// LSU-side handshake plus register-file / IFU redirect signals of the
// writeback commit queue.
interface wbu_commit_queue_if #(
   parameter int XLEN = 32
);
   import cpu_types_pkg::*;

   // valid/ready: an entry transfers on a rising edge where in_valid and
   // in_ready are both 1; in_ready depends only on registered occupancy.
   logic             in_valid;
   logic             in_ready;
   logic             in_entry_valid;
   logic [RD_W-1:0]  in_rd_addr;
   logic [XLEN-1:0]  in_wb_data;
   logic             in_reg_wen;
   logic [XLEN-1:0]  in_pc_target;
   logic             redirect_ready;
   logic             flush;
   logic             rf_wen;
   logic [RD_W-1:0]  rf_addr;
   logic [XLEN-1:0]  rf_data;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_target;
   logic             empty;

   modport master (
      output in_valid, in_entry_valid, in_rd_addr, in_wb_data, in_reg_wen,
             in_pc_target, redirect_ready, flush,
      input  in_ready, rf_wen, rf_addr, rf_data, redirect_valid,
             redirect_target, empty
   );

   modport slave (
      input  in_valid, in_entry_valid, in_rd_addr, in_wb_data, in_reg_wen,
             in_pc_target, redirect_ready, flush,
      output in_ready, rf_wen, rf_addr, rf_data, redirect_valid,
             redirect_target, empty
   );

endinterface

// File: rtl/wbu_fifo.sv
// DEPTH-entry FIFO of packed writeback entries with synchronous clear.
// The caller never pushes when full nor pops when empty.
module wbu_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 70
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_push,
   input  logic [W-1:0]           i_wdata,
   input  logic                   i_pop,
   input  logic                   i_clear,
   output logic [W-1:0]           o_rdata,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);

   generate
      if (DEPTH == 1) begin : g_single
         logic         r_occ;
         logic [W-1:0] r_mem;

         always_ff @(posedge clk) begin
            if (!rst) begin
               r_occ <= 1'b0;
               r_mem <= '0;
            end else if (i_clear) begin
               r_occ <= 1'b0;
            end else begin
               if (i_push) r_mem <= i_wdata;
               r_occ <= i_push | (r_occ & ~i_pop);
            end
         end

         assign o_rdata = r_mem;
         assign o_count = r_occ;
         assign o_empty = ~r_occ;
      end else begin : g_multi
         localparam int PTR_W = $clog2(DEPTH);
         logic [PTR_W-1:0] r_rd_ptr;
         logic [PTR_W-1:0] r_wr_ptr;
         logic [PTR_W:0]   r_count;
         logic [W-1:0]     r_mem [DEPTH];

         always_ff @(posedge clk) begin
            if (!rst) begin
               r_rd_ptr <= '0;
               r_wr_ptr <= '0;
               r_count  <= '0;
               for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
            end else if (i_clear) begin
               r_rd_ptr <= '0;
               r_wr_ptr <= '0;
               r_count  <= '0;
            end else begin
               if (i_push) begin
                  r_mem[r_wr_ptr] <= i_wdata;
                  r_wr_ptr        <= r_wr_ptr + 1'b1;
               end
               if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
               case ({i_push, i_pop})
                  2'b10:   r_count <= r_count + 1'b1;
                  2'b01:   r_count <= r_count - 1'b1;
                  default: r_count <= r_count;
               endcase
            end
         end

         assign o_rdata = r_mem[r_rd_ptr];
         assign o_count = r_count;
         assign o_empty = (r_count == '0);
      end
   endgenerate

endmodule

// File: rtl/wbu_commit_queue.sv
// Writeback/commit queue: buffers completed LSU entries and retires at most
// one per cycle to the register file and the IFU redirect port.
module wbu_commit_queue
   import cpu_types_pkg::*;
#(
   parameter int DEPTH     = 2,
   parameter int PIPELINED = 1,
   parameter int XLEN      = 32,
   parameter int CNT_W     = 64
) (
   input  logic              clk,
   input  logic              rst,
   wbu_commit_queue_if.slave bus,
   output logic [CNT_W-1:0]  retired_cnt
);

   localparam int OCC_W   = $clog2(DEPTH) + 1;
   localparam int ENTRY_W = entry_w(XLEN);
   localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

   // Same field order as wb_entry_t, sized by this instance's XLEN.
   typedef struct packed {
      logic [RD_W-1:0] rd_addr;
      logic [XLEN-1:0] wb_data;
      logic            reg_wen;
      logic [XLEN-1:0] pc_target;
   } entry_t;

   entry_t             w_wr_entry;
   entry_t             w_head;
   logic [ENTRY_W-1:0] w_rdata;
   logic [OCC_W-1:0]   w_count;
   logic               w_empty;
   logic               w_ready;
   logic               w_in_fire;
   logic               w_push;
   logic               w_commit;
   logic [CNT_W-1:0]   r_retired;

   // Streaming mode accepts until full; legacy mode only into an empty queue.
   assign w_ready   = (PIPELINED != 0) ? (w_count != FULL_OCC) : w_empty;
   assign w_in_fire = bus.in_valid & w_ready;
   assign w_push    = w_in_fire & bus.in_entry_valid & ~bus.flush;
   assign w_commit  = rst & ~w_empty & bus.redirect_ready & ~bus.flush;

   assign w_wr_entry.rd_addr   = bus.in_rd_addr;
   assign w_wr_entry.wb_data   = bus.in_wb_data;
   assign w_wr_entry.reg_wen   = bus.in_reg_wen;
   assign w_wr_entry.pc_target = bus.in_pc_target;
   assign w_head               = entry_t'(w_rdata);

   wbu_fifo #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_wr_entry),
      .i_pop   (w_commit),
      .i_clear (bus.flush),
      .o_rdata (w_rdata),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_retired <= '0;
      end else if (w_commit) begin
         r_retired <= r_retired + 1'b1;
      end
   end

   // Writes to x0 still retire and redirect, but never reach the register file.
   assign bus.rf_wen          = w_commit & w_head.reg_wen & (w_head.rd_addr != '0);
   assign bus.redirect_valid  = w_commit;
   assign bus.rf_addr         = w_head.rd_addr;
   assign bus.rf_data         = w_head.wb_data;
   assign bus.redirect_target = w_head.pc_target;
   assign bus.in_ready        = w_ready;
   assign bus.empty           = w_empty;
   assign retired_cnt         = r_retired;

endmodule

// File: tb/tb_wbu_commit_queue.sv
// Directed bench for wbu_commit_queue: instance A is streaming with a 4-bit
// counter, instance B is the legacy one-entry alternation.
module tb_wbu_commit_queue;

   localparam int DEPTH = 2;
   localparam int EW    = 70;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wbu_commit_queue_if #(.XLEN(32)) bus_a ();
   wbu_commit_queue_if #(.XLEN(32)) bus_b ();
   logic [3:0]  cnt_a;
   logic [63:0] cnt_b;

   wbu_commit_queue #(.DEPTH(DEPTH), .PIPELINED(1), .XLEN(32), .CNT_W(4)) u_dut_a (
      .clk(clk), .rst(rst), .bus(bus_a), .retired_cnt(cnt_a));
   wbu_commit_queue #(.DEPTH(DEPTH), .PIPELINED(0), .XLEN(32), .CNT_W(64)) u_dut_b (
      .clk(clk), .rst(rst), .bus(bus_b), .retired_cnt(cnt_b));

   // ---------------- driver signals ----------------
   logic        d_valid [2];
   logic        d_ev    [2];
   logic [4:0]  d_rd    [2];
   logic [31:0] d_data  [2];
   logic        d_wen   [2];
   logic [31:0] d_pc    [2];
   logic        d_rr    [2];
   logic        d_flush [2];

   assign bus_a.in_valid       = d_valid[0];
   assign bus_a.in_entry_valid = d_ev[0];
   assign bus_a.in_rd_addr     = d_rd[0];
   assign bus_a.in_wb_data     = d_data[0];
   assign bus_a.in_reg_wen     = d_wen[0];
   assign bus_a.in_pc_target   = d_pc[0];
   assign bus_a.redirect_ready = d_rr[0];
   assign bus_a.flush          = d_flush[0];
   assign bus_b.in_valid       = d_valid[1];
   assign bus_b.in_entry_valid = d_ev[1];
   assign bus_b.in_rd_addr     = d_rd[1];
   assign bus_b.in_wb_data     = d_data[1];
   assign bus_b.in_reg_wen     = d_wen[1];
   assign bus_b.in_pc_target   = d_pc[1];
   assign bus_b.redirect_ready = d_rr[1];
   assign bus_b.flush          = d_flush[1];

   logic        o_ready [2];
   logic        o_wen   [2];
   logic [4:0]  o_addr  [2];
   logic [31:0] o_data  [2];
   logic        o_rv    [2];
   logic [31:0] o_tgt   [2];
   logic        o_empty [2];
   logic [63:0] o_cnt   [2];

   assign o_ready[0] = bus_a.in_ready;       assign o_ready[1] = bus_b.in_ready;
   assign o_wen[0]   = bus_a.rf_wen;         assign o_wen[1]   = bus_b.rf_wen;
   assign o_addr[0]  = bus_a.rf_addr;        assign o_addr[1]  = bus_b.rf_addr;
   assign o_data[0]  = bus_a.rf_data;        assign o_data[1]  = bus_b.rf_data;
   assign o_rv[0]    = bus_a.redirect_valid; assign o_rv[1]    = bus_b.redirect_valid;
   assign o_tgt[0]   = bus_a.redirect_target; assign o_tgt[1]  = bus_b.redirect_target;
   assign o_empty[0] = bus_a.empty;          assign o_empty[1] = bus_b.empty;
   assign o_cnt[0]   = {60'd0, cnt_a};       assign o_cnt[1]   = cnt_b;

   // ---------------- scoreboard / model ----------------
   // Entry packing used by the bench: {rd[69:65], data[64:33], wen[32], pc[31:0]}.
   logic [EW-1:0] exp_q0 [$];
   logic [EW-1:0] exp_q1 [$];
   logic [63:0]   exp_cnt [2];
   bit            acc [2];
   bit            chk_en = 1'b0;
   int            cmp_n  = 0;
   int            fail_n = 0;

   function automatic int q_size(input int i);
      return (i == 0) ? exp_q0.size() : exp_q1.size();
   endfunction

   function automatic logic [EW-1:0] q_head(input int i);
      if (q_size(i) == 0) return '0;
      return (i == 0) ? exp_q0[0] : exp_q1[0];
   endfunction

   function automatic void q_push(input int i, input logic [EW-1:0] e);
      if (i == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
   endfunction

   function automatic void q_pop(input int i);
      if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
   endfunction

   function automatic void q_clear(input int i);
      if (i == 0) exp_q0.delete(); else exp_q1.delete();
   endfunction

   function automatic logic [63:0] cnt_mask(input int i);
      return (i == 0) ? 64'hF : 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   function automatic logic m_ready(input int i);
      if (i == 0) return q_size(i) != DEPTH;
      return q_size(i) == 0;
   endfunction

   function automatic logic m_commit(input int i);
      return rst && (q_size(i) != 0) && d_rr[i] && !d_flush[i];
   endfunction

   task automatic check(input string nm, input int i, input logic [63:0] act,
                        input logic [63:0] exp);
      cmp_n++;
      if (act !== exp) begin
         fail_n++;
         $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, i, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin : model
      logic rdy, com;
      for (int i = 0; i < 2; i++) begin
         rdy    = m_ready(i);
         com    = m_commit(i);
         acc[i] = d_valid[i] && rdy;
         if (!rst) begin
            q_clear(i);
            exp_cnt[i] = '0;
         end else if (d_flush[i]) begin
            q_clear(i);
         end else begin
            if (com) begin
               q_pop(i);
               exp_cnt[i] = (exp_cnt[i] + 64'd1) & cnt_mask(i);
            end
            if (d_valid[i] && rdy && d_ev[i])
               q_push(i, {d_rd[i], d_data[i], d_wen[i], d_pc[i]});
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [EW-1:0] h;
      logic          com;
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            h   = q_head(i);
            com = m_commit(i);
            check("in_ready", i, 64'(o_ready[i]), 64'(m_ready(i)));
            check("empty", i, 64'(o_empty[i]), 64'(q_size(i) == 0));
            check("redirect_valid", i, 64'(o_rv[i]), 64'(com));
            check("rf_wen", i, 64'(o_wen[i]), 64'(com && h[32] && (h[69:65] != 5'd0)));
            check("retired_cnt", i, o_cnt[i], exp_cnt[i]);
            if (q_size(i) != 0) begin
               check("rf_addr", i, 64'(o_addr[i]), 64'(h[69:65]));
               check("rf_data", i, 64'(o_data[i]), 64'(h[64:33]));
               check("redirect_target", i, 64'(o_tgt[i]), 64'(h[31:0]));
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int i, input logic v, input logic ev, input logic [4:0] rd,
                        input logic [31:0] data, input logic wen, input logic [31:0] pc);
      d_valid[i] = v;
      d_ev[i]    = ev;
      d_rd[i]    = rd;
      d_data[i]  = data;
      d_wen[i]   = wen;
      d_pc[i]    = pc;
   endtask

   task automatic idle(input int i);
      drive(i, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: run exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed stimulus ----------------
   initial begin : stim
      int k;
      for (int i = 0; i < 2; i++) begin
         idle(i);
         d_rr[i]    = 1'b1;
         d_flush[i] = 1'b0;
      end
      rst = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b1;

      // Reset state.
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_ready", i, 64'(o_ready[i]), 64'd1);
         check("rst_empty", i, 64'(o_empty[i]), 64'd1);
         check("rst_addr", i, 64'(o_addr[i]), 64'd0);
         check("rst_data", i, 64'(o_data[i]), 64'd0);
         check("rst_tgt", i, 64'(o_tgt[i]), 64'd0);
         check("rst_wen", i, 64'(o_wen[i]), 64'd0);
         check("rst_rv", i, 64'(o_rv[i]), 64'd0);
         check("rst_cnt", i, o_cnt[i], 64'd0);
      end

      // Single entry commits the cycle after acceptance.
      tick();
      for (int i = 0; i < 2; i++) drive(i, 1, 1, 5'd5, 32'hDEAD_BEEF, 1, 32'h8000_0004);
      tick();
      for (int i = 0; i < 2; i++) idle(i);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("t1_wen", i, 64'(o_wen[i]), 64'd1);
         check("t1_addr", i, 64'(o_addr[i]), 64'd5);
         check("t1_data", i, 64'(o_data[i]), 64'hDEAD_BEEF);
         check("t1_rv", i, 64'(o_rv[i]), 64'd1);
         check("t1_tgt", i, 64'(o_tgt[i]), 64'h8000_0004);
      end
      tick();
      @(negedge clk);
      for (int i = 0; i < 2; i++) check("t1_cnt", i, o_cnt[i], 64'd1);

      // x0 write suppressed but still retires; bubble is dropped.
      tick();
      for (int i = 0; i < 2; i++) drive(i, 1, 1, 5'd0, 32'h1234_5678, 1, 32'h8000_0008);
      tick();
      for (int i = 0; i < 2; i++) idle(i);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("x0_rv", i, 64'(o_rv[i]), 64'd1);
         check("x0_wen", i, 64'(o_wen[i]), 64'd0);
      end
      tick();
      for (int i = 0; i < 2; i++) drive(i, 1, 0, 5'd7, 32'h5555_5555, 1, 32'h9000_0000);
      tick();
      for (int i = 0; i < 2; i++) idle(i);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("bub_empty", i, 64'(o_empty[i]), 64'd1);
         check("bub_rv", i, 64'(o_rv[i]), 64'd0);
         check("bub_cnt", i, o_cnt[i], 64'd2);
      end

      // Backpressure: three back-to-back offers with the IFU stalled.
      tick();
      for (int i = 0; i < 2; i++) d_rr[i] = 1'b0;
      for (int j = 0; j < 3; j++) begin
         for (int i = 0; i < 2; i++)
            drive(i, 1, 1, 5'(j + 1), 32'hA000_0000 + 32'(j), 1, 32'h2000 + 32'(4 * j));
         if (j == 2) begin
            @(negedge clk);
            check("full_ready", 0, 64'(o_ready[0]), 64'd0);
            check("full_ready", 1, 64'(o_ready[1]), 64'd0);
         end
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         idle(i);
         d_rr[i] = 1'b1;
      end
      @(negedge clk);
      check("order0_addr", 0, 64'(o_addr[0]), 64'd1);
      check("order0_rv", 0, 64'(o_rv[0]), 64'd1);
      tick();
      @(negedge clk);
      check("order1_addr", 0, 64'(o_addr[0]), 64'd2);
      check("order1_data", 0, 64'(o_data[0]), 64'hA000_0001);
      tick();
      tick();
      @(negedge clk);
      check("bp_cnt", 0, o_cnt[0], 64'd4);
      check("bp_cnt", 1, o_cnt[1], 64'd3);

      // Legacy alternation on B: in_valid held high, 4 entries over 8 cycles.
      tick();
      k = 0;
      for (int c = 0; c < 8; c++) begin
         drive(1, 1, 1, 5'(10 + k), 32'hB000_0000 + 32'(k), 1, 32'h3000 + 32'(4 * k));
         @(negedge clk);
         check("alt_ready", 1, 64'(o_ready[1]), 64'((c % 2) == 0));
         tick();
         if (acc[1]) k++;
      end
      idle(1);
      @(negedge clk);
      check("alt_cnt", 1, o_cnt[1], 64'd7);

      // Flush on A while an entry is buffered and another is accepted.
      tick();
      d_rr[0] = 1'b0;
      drive(0, 1, 1, 5'd20, 32'hC000_0020, 1, 32'h4000);
      tick();
      drive(0, 1, 1, 5'd21, 32'hC000_0021, 1, 32'h4004);
      d_flush[0] = 1'b1;
      d_rr[0]    = 1'b1;
      @(negedge clk);
      check("fl_rv", 0, 64'(o_rv[0]), 64'd0);
      check("fl_wen", 0, 64'(o_wen[0]), 64'd0);
      tick();
      idle(0);
      d_flush[0] = 1'b0;
      @(negedge clk);
      check("fl_empty", 0, 64'(o_empty[0]), 64'd1);
      check("fl_ready", 0, 64'(o_ready[0]), 64'd1);
      tick();
      tick();
      @(negedge clk);
      check("fl_cnt", 0, o_cnt[0], 64'd4);

      // Counter wrap: 17 retirements on the 4-bit counter from reset.
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      for (int j = 0; j < 17; j++) begin
         drive(0, 1, 1, 5'((j % 31) + 1), 32'(j), 1, 32'(4 * j));
         tick();
      end
      idle(0);
      tick();
      @(negedge clk);
      check("wrap_cnt", 0, o_cnt[0], 64'd1);
      check("wrap_empty", 0, 64'(o_empty[0]), 64'd1);

      // Reset while two entries are buffered.
      tick();
      d_rr[0] = 1'b0;
      drive(0, 1, 1, 5'd30, 32'hD000_0030, 1, 32'h5000);
      tick();
      drive(0, 1, 1, 5'd31, 32'hD000_0031, 1, 32'h5004);
      tick();
      idle(0);
      d_rr[0] = 1'b1;
      rst     = 1'b0;
      @(negedge clk);
      check("mrst_rv", 0, 64'(o_rv[0]), 64'd0);
      check("mrst_wen", 0, 64'(o_wen[0]), 64'd0);
      tick();
      rst = 1'b1;
      @(negedge clk);
      check("mrst_empty", 0, 64'(o_empty[0]), 64'd1);
      check("mrst_ready", 0, 64'(o_ready[0]), 64'd1);
      check("mrst_cnt", 0, o_cnt[0], 64'd0);
      check("mrst_cnt", 1, o_cnt[1], 64'd0);

      tick();
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
      $finish;
   end

endmodule
